// File: rtl/axi4_burst_writer.sv
// AXI4 write master: buffers a sample stream in a FIFO and drains it as fixed-length
// INCR bursts into a ring buffer in memory, one burst outstanding at a time.
module axi4_burst_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH-1:0]   buf_bytes,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   wr_ptr,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH  = IDX_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT   = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  BURST_CNT   = CNT_WIDTH'(BURST_LEN);
  localparam logic [8:0]            LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * STRB_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0]  head, tail;
  logic [CNT_WIDTH-1:0]  count;
  logic                  push, pop;

  logic [8:0]            beat, beat_next;
  logic [ADDR_WIDTH-1:0] offset, offset_inc, offset_next;
  logic                  enable_d, restart;
  logic                  aw_fire, b_fire;

  assign m_awlen   = 8'(BURST_LEN - 1);
  assign m_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_awburst = 2'b01;
  assign m_wstrb   = '1;

  assign s_tready = (count < DEPTH_CNT);
  assign push     = s_tvalid && s_tready;
  assign pop      = m_wvalid && m_wready;
  assign m_wdata  = mem[head];
  assign aw_fire  = m_awvalid && m_awready;
  assign b_fire   = m_bvalid && m_bready;

  // A rising edge of enable seen while idle restarts the ring from offset zero.
  assign restart = (state == IDLE) && enable && !enable_d;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[tail] <= s_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + IDX_WIDTH'(1);
      end
      if (pop) begin
        head <= head + IDX_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wrap uses >= so a stray offset can never run past the ring; legal configs hit equality.
  always_comb begin
    state_next  = state;
    beat_next   = beat;
    offset_inc  = offset + BURST_BYTES;
    offset_next = (offset_inc >= buf_bytes) ? '0 : offset_inc;
    unique case (state)
      IDLE: begin
        if (enable && (count >= BURST_CNT)) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (aw_fire) begin
          state_next = DATA;
          beat_next  = '0;
        end
      end
      DATA: begin
        if (pop) begin
          beat_next = beat + 9'd1;
          if (beat == LAST_BEAT) begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (b_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat      <= '0;
      offset    <= '0;
      wr_ptr    <= '0;
      resp_err  <= 1'b0;
      enable_d  <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_wlast   <= 1'b0;
      m_bready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      beat      <= beat_next;
      enable_d  <= enable;
      m_awvalid <= (state_next == ADDR);
      m_wvalid  <= (state_next == DATA);
      m_wlast   <= (state_next == DATA) && (beat_next == LAST_BEAT);
      m_bready  <= (state_next == RESP);
      busy      <= (state_next != IDLE);
      if (restart) begin
        offset   <= '0;
        wr_ptr   <= '0;
        resp_err <= 1'b0;
      end
      if ((state == IDLE) && (state_next == ADDR)) begin
        m_awaddr <= base_addr + (restart ? '0 : offset);
      end
      if ((state == RESP) && b_fire) begin
        offset   <= offset_next;
        wr_ptr   <= offset_next;
        resp_err <= resp_err | (m_bresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_writer.sv
// Self-checking bench for axi4_burst_writer: randomised AXI slave timing, a word
// scoreboard and a ring-buffer model computed from burst counts.
module tb_axi4_burst_writer;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int BL = 16;
  localparam int FD = 64;
  localparam int BB = BL * DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] buf_bytes;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_awvalid;
  logic          m_awready;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic          m_wlast;
  logic          m_wvalid;
  logic          m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid;
  logic          m_bready;
  logic [AW-1:0] wr_ptr;
  logic          resp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int  model_count = 0;
  int  k_aw = 0, k_w = 0, k_b = 0;
  bit  err_model = 1'b0;
  int  err_at = -1;
  int  max_delay = 0;
  int  beat_idx = 0, b_pending = 0, b_done = 0;
  int  aw_wait = 0, w_wait = 0, b_wait = 0;
  int  cyc = 0, last_push_cyc = 0, aw_first_cyc = 0, b_cyc = 0;
  bit  aw_seen = 1'b0, b_fire = 1'b0, b_check = 1'b0;
  logic [AW-1:0] exp_wr_ptr = '0;
  logic [AW-1:0] last_awaddr = '0;

  axi4_burst_writer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_LEN (BL),
    .FIFO_DEPTH(FD)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .enable   (enable),
    .base_addr(base_addr),
    .buf_bytes(buf_bytes),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_awaddr (m_awaddr),
    .m_awlen  (m_awlen),
    .m_awsize (m_awsize),
    .m_awburst(m_awburst),
    .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_wlast  (m_wlast),
    .m_wvalid (m_wvalid),
    .m_wready (m_wready),
    .m_bresp  (m_bresp),
    .m_bvalid (m_bvalid),
    .m_bready (m_bready),
    .wr_ptr   (wr_ptr),
    .resp_err (resp_err),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // The k-th burst since a restart lands k bursts into the ring, modulo its size.
  function automatic logic [AW-1:0] ring_offset(input int k);
    return AW'((longint'(k) * BB) % longint'(buf_bytes));
  endfunction

  task automatic apply_stimulus(input int n, input bit counting);
    for (int i = 0; i < n; i++) begin
      if (counting) src_q.push_back(DW'(i));
      else          src_q.push_back({$urandom, $urandom});
    end
  endtask

  task automatic restart_model();
    k_aw = 0;
    k_w = 0;
    k_b = 0;
    err_model = 1'b0;
  endtask

  task automatic wait_bursts(input string tag, input int target, input int limit);
    int t = 0;
    while (b_done < target && t < limit) begin
      @(negedge aclk);
      t++;
    end
    check_output({tag, ".burst_timeout"}, 128'(b_done >= target), 128'(1));
    repeat (2) @(negedge aclk);
  endtask

  task automatic wait_beat(input string tag, input int beat, input int limit);
    int t = 0;
    while (!(m_wvalid && beat_idx >= beat) && t < limit) begin
      @(negedge aclk);
      t++;
    end
    check_output({tag, ".beat_timeout"}, 128'(m_wvalid && beat_idx >= beat), 128'(1));
  endtask

  task automatic toggle_enable(input string tag);
    enable = 1'b0;
    repeat (3) @(negedge aclk);
    enable = 1'b1;
    restart_model();
    repeat (2) @(negedge aclk);
    check_output({tag, ".wr_ptr_clear"}, wr_ptr, 0);
    check_output({tag, ".resp_err_clear"}, resp_err, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".awvalid"}, m_awvalid, 0);
    check_output({tag, ".wvalid"}, m_wvalid, 0);
    check_output({tag, ".wlast"}, m_wlast, 0);
    check_output({tag, ".bready"}, m_bready, 0);
    check_output({tag, ".busy"}, busy, 0);
    check_output({tag, ".resp_err"}, resp_err, 0);
    check_output({tag, ".wr_ptr"}, wr_ptr, 0);
    check_output({tag, ".s_tready"}, s_tready, 1);
    check_output({tag, ".awlen"}, m_awlen, BL - 1);
    check_output({tag, ".awsize"}, m_awsize, 3);
    check_output({tag, ".awburst"}, m_awburst, 1);
    check_output({tag, ".wstrb"}, m_wstrb, 8'hff);
  endtask

  // Source, AXI slave and scoreboard: each negedge decides what fires at the next posedge.
  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      s_tvalid = 1'b0;
      m_awready = 1'b0;
      m_wready = 1'b0;
      m_bvalid = 1'b0;
      m_bresp = 2'b00;
      exp_q.delete();
      model_count = 0;
      beat_idx = 0;
      b_pending = 0;
      aw_wait = 0;
      w_wait = 0;
      b_wait = 0;
      aw_seen = 1'b0;
      b_fire = 1'b0;
      b_check = 1'b0;
      restart_model();
    end else begin
      int push_n;
      int pop_n;
      push_n = 0;
      pop_n = 0;

      if (b_check) begin
        check_output("b.wr_ptr", wr_ptr, exp_wr_ptr);
        check_output("b.resp_err", resp_err, err_model);
        check_output("b.busy_after", busy, 0);
        b_check = 1'b0;
      end

      check_output("s_tready", s_tready, model_count < FD);
      if (src_q.size() > 0) begin
        s_tvalid = 1'b1;
        s_tdata = src_q[0];
        if (model_count < FD) begin
          exp_q.push_back(src_q.pop_front());
          push_n = 1;
          last_push_cyc = cyc;
        end
      end else begin
        s_tvalid = 1'b0;
      end

      if (b_fire) begin
        m_bvalid = 1'b0;
        b_fire = 1'b0;
      end
      if (!m_bvalid && b_pending > 0) begin
        if (b_wait == 0) begin
          m_bvalid = 1'b1;
          m_bresp = (k_b == err_at) ? 2'b10 : 2'b00;
        end else begin
          b_wait--;
        end
      end
      if (m_bvalid && m_bready) begin
        b_fire = 1'b1;
        b_pending--;
        err_model = err_model | (m_bresp != 2'b00);
        k_b++;
        exp_wr_ptr = ring_offset(k_b);
        b_done++;
        b_cyc = cyc;
        b_check = 1'b1;
        b_wait = $urandom_range(0, max_delay);
      end

      if (m_awvalid) begin
        if (!aw_seen) begin
          aw_seen = 1'b1;
          aw_first_cyc = cyc;
        end
        check_output("aw.addr", m_awaddr, base_addr + ring_offset(k_aw));
        check_output("aw.one_outstanding", k_b, k_aw);
        if (aw_wait == 0) begin
          m_awready = 1'b1;
          last_awaddr = m_awaddr;
          k_aw++;
          aw_seen = 1'b0;
          aw_wait = $urandom_range(0, max_delay);
        end else begin
          m_awready = 1'b0;
          aw_wait--;
        end
      end else begin
        m_awready = 1'b0;
      end

      if (m_wvalid) begin
        check_output("w.after_aw", k_aw, k_w + 1);
        check_output("w.queued", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_output("w.data", m_wdata, exp_q[0]);
        check_output("w.last", m_wlast, beat_idx == BL - 1);
        if (w_wait == 0) begin
          m_wready = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          pop_n = 1;
          beat_idx++;
          if (beat_idx == BL) begin
            beat_idx = 0;
            k_w++;
            b_pending++;
          end
          w_wait = $urandom_range(0, max_delay);
        end else begin
          m_wready = 1'b0;
          w_wait--;
        end
      end else begin
        m_wready = 1'b0;
      end

      model_count = model_count + push_n - pop_n;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    aresetn = 1'b0;
    enable = 1'b0;
    base_addr = 32'h1000_0000;
    buf_bytes = 32'h200;
    s_tvalid = 1'b0;
    s_tdata = '0;
    m_awready = 1'b0;
    m_wready = 1'b0;
    m_bvalid = 1'b0;
    m_bresp = 2'b00;
    repeat (3) @(negedge aclk);
    check_reset_values("reset");
    aresetn = 1'b1;
    @(negedge aclk);

    $display("[TB] basic burst");
    enable = 1'b1;
    restart_model();
    repeat (2) @(negedge aclk);
    apply_stimulus(BL, 1'b1);
    wait_bursts("basic", 1, 300);
    check_output("basic.aw_latency", aw_first_cyc - last_push_cyc, 2);
    check_output("basic.burst_cycles", b_cyc - aw_first_cyc, BL + 1);
    check_output("basic.awaddr", last_awaddr, 32'h1000_0000);
    check_output("basic.wr_ptr", wr_ptr, 32'h80);
    check_output("basic.busy", busy, 0);

    $display("[TB] ring wrap");
    toggle_enable("wrap");
    start = b_done;
    apply_stimulus(80, 1'b0);
    wait_bursts("wrap", start + 5, 1000);
    check_output("wrap.aw_count", k_aw, 5);
    check_output("wrap.last_awaddr", last_awaddr, 32'h1000_0000);
    check_output("wrap.wr_ptr", wr_ptr, 32'h80);

    $display("[TB] backpressure");
    toggle_enable("bp");
    max_delay = 7;
    start = b_done;
    apply_stimulus(192, 1'b0);
    wait_bursts("bp", start + 12, 20000);
    check_output("bp.aw_count", k_aw, 12);
    check_output("bp.s_tready", s_tready, 1);
    check_output("bp.busy", busy, 0);
    max_delay = 0;
    aw_wait = 0;
    w_wait = 0;
    b_wait = 0;

    $display("[TB] error response");
    toggle_enable("err");
    err_at = 1;
    start = b_done;
    apply_stimulus(48, 1'b0);
    wait_bursts("err", start + 3, 1000);
    check_output("err.third_burst", k_aw, 3);
    check_output("err.sticky", resp_err, 1);
    err_at = -1;
    toggle_enable("err_clear");

    $display("[TB] disable mid-burst");
    start = b_done;
    apply_stimulus(36, 1'b0);
    wait_beat("dis", 5, 300);
    enable = 1'b0;
    wait_bursts("dis", start + 1, 300);
    repeat (30) @(negedge aclk);
    check_output("dis.aw_count", k_aw, 1);
    check_output("dis.awvalid", m_awvalid, 0);
    check_output("dis.busy", busy, 0);

    $display("[TB] reset mid-burst");
    enable = 1'b1;
    restart_model();
    wait_beat("rst", 8, 300);
    #1 aresetn = 1'b0;
    @(negedge aclk);
    check_reset_values("rst_early");
    repeat (24) @(negedge aclk);
    check_reset_values("rst_late");
    aresetn = 1'b1;
    @(negedge aclk);
    start = b_done;
    apply_stimulus(BL, 1'b0);
    wait_bursts("rst", start + 1, 300);
    check_output("rst.awaddr", last_awaddr, 32'h1000_0000);
    check_output("rst.wr_ptr", wr_ptr, 32'h80);
    check_output("rst.aw_count", k_aw, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_burst_writer.md
# axi4_burst_writer

Parametrised AXI4 write master that drains a sample stream into a ring buffer in DDR through a Zynq HP port. It is the next-generation master behind the axi_4 block design, with configurable data width, burst length and FIFO depth. It adds ring-buffer wrap-around, backpressure to the sample source, a one-burst-outstanding write-response check and status reporting. It sits between the vibrometer sample pipeline (AXI4-Stream-like input) and the AXI interconnect / AXI VIP slave.

## Interface
- DATA_WIDTH, 64, AXI data and stream width in bits (32, 64 or 128).
- ADDR_WIDTH, 32, AXI address width.
- BURST_LEN, 16, beats per burst (power of 2, 1..256).
- FIFO_DEPTH, 64, input FIFO entries (power of 2, ≥ BURST_LEN).

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- enable  in  1  run control.
- base_addr  in  ADDR_WIDTH  ring start; aligned to BURST_LEN*DATA_WIDTH/8.
- buf_bytes  in  ADDR_WIDTH  ring size; a non-zero multiple of the burst bytes.
- s_tdata  in  DATA_WIDTH  sample word.
- s_tvalid  in  1  sample valid.
- s_tready  out  1  FIFO not full.
- m_awaddr  out  ADDR_WIDTH  burst address.
- m_awlen  out  8  constant BURST_LEN-1.
- m_awsize  out  3  constant log2(DATA_WIDTH/8).
- m_awburst  out  2  constant 2'b01 (INCR).
- m_awvalid  in/out  out 1, with m_awready in 1.
- m_wdata  out  DATA_WIDTH  FIFO head.
- m_wstrb  out  DATA_WIDTH/8  all ones.
- m_wlast  out  1  final beat of the burst.
- m_wvalid  out 1, with m_wready in 1.
- m_bresp  in  2  write response.
- m_bvalid  in 1, with m_bready out 1.
- wr_ptr  out  ADDR_WIDTH  byte offset, relative to base_addr, of the end of the last acknowledged burst.
- resp_err  out  1  sticky: some bresp was not OKAY.
- busy  out  1  state ≠ IDLE.

## Operation
- The FIFO accepts a word on s_tvalid && s_tready.
  - s_tready = (count < FIFO_DEPTH).
  - Simultaneous push and pop leave count unchanged.
- FSM states:
  - IDLE → ADDR when enable && count ≥ BURST_LEN.
  - ADDR drives m_awvalid with m_awaddr = base_addr + offset, and moves to DATA on the AW handshake.
  - DATA drives m_wvalid = 1 and pops the FIFO on each W handshake. The beat counter runs 0..BURST_LEN-1; m_wlast = 1 at BURST_LEN-1. The last handshake moves to RESP.
  - RESP drives m_bready = 1. On the B handshake:
    - resp_err |= (bresp ≠ 2'b00);
    - offset += BURST_LEN*DATA_WIDTH/8, and wraps to 0 when it equals buf_bytes;
    - wr_ptr ← the new offset;
    - → IDLE.
- Exactly one burst is outstanding. W is never driven before the AW handshake, and m_wvalid never drops mid-burst.
- The DATA-state beat count is guaranteed, because the FIFO held ≥ BURST_LEN entries at IDLE exit.
- enable deassertion takes effect only in IDLE. A burst in progress always completes through RESP. Words left in the FIFO are retained.
- Re-enable behaviour: on a 0→1 edge of enable while in IDLE, offset and wr_ptr are cleared to 0 and resp_err is cleared.
- base_addr and buf_bytes are sampled only when used. Software changes them only while enable = 0 and busy = 0.
- Bursts never cross a 4 KB boundary, given the alignment rules above and a burst of at most 4096 bytes.

## Timing
- Reset values of all outputs: awvalid, wvalid, wlast, bready, busy, resp_err = 0; wr_ptr = 0; s_tready = 1. The FIFO is emptied and the FSM is in IDLE.
- Constant outputs (awlen, awsize, awburst, wstrb) are valid from reset onward.
- Latency:
  - m_awvalid rises 1 cycle after the push that makes count reach BURST_LEN, provided the FSM is IDLE and enable = 1.
  - m_wvalid rises the cycle after the AW handshake.
- Handshakes:
  - Every valid holds until its ready.
  - Payloads are stable while valid && !ready.
  - Zero-wait slave timing: a burst takes BURST_LEN + 3 cycles, IDLE to IDLE.
- Every output is registered, except m_wdata (FIFO head) and s_tready, which are driven from registered state.
- Reset mid-burst: all state is cleared immediately and asynchronously. No partial-burst recovery is attempted.

## Test plan
- Basic burst:
  - Config: defaults, base 0x1000_0000, buf_bytes 0x200, enable = 1; push 16 words 0..15.
  - One AW at 0x1000_0000 with awlen 15, awsize 3, awburst 1.
  - 16 W beats carrying 0..15, wlast on beat 15.
  - After B OKAY: wr_ptr = 0x80, busy = 0.
- Wrap:
  - Push 80 words continuously.
  - AW addresses 0x1000_0000, 0x80, 0x100, 0x180, then 0x1000_0000 again.
  - wr_ptr sequence 0x80, 0x100, 0x180, 0x0, 0x80.
- Backpressure:
  - Random awready/wready/bvalid delays of 0–7 cycles; source pushes every cycle.
  - No data loss or reordering against a scoreboard.
  - s_tready = 0 exactly while count = 64.
  - Payloads stable under stall.
- Error response:
  - VIP returns SLVERR on the 2nd burst.
  - resp_err = 1 and stays set; the 3rd burst still issues.
  - Toggling enable 0→1 in IDLE clears resp_err and wr_ptr.
- Disable mid-burst:
  - Drop enable during beat 5.
  - The burst completes all 16 beats plus B, then IDLE.
  - No further AW although 20 words remain queued.
- Reset mid-burst:
  - Assert aresetn = 0 during beat 8 for 25 cycles, then release.
  - All outputs at reset values during reset.
  - Fresh bursts start at offset 0 after new data.
